// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the v1 8-bit datapath.
//   ACC_W       : accumulator / datapath width (the flags block only handles 8).
//   alu_op_t    : 4-bit ALU opcode; codes 14 and 15 are unassigned and act as NOP.
//   alu_state_t : ALU sequencing state (IDLE, or iterating a multiply).
package cpu_pkg;

  localparam int ACC_W = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LD  = 4'd1,
    OP_ADD = 4'd2,
    OP_ADC = 4'd3,
    OP_SUB = 4'd4,
    OP_SBC = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_XOR = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10,
    OP_RLC = 4'd11,
    OP_RRC = 4'd12,
    OP_MUL = 4'd13
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_acc_if.sv
// alu_acc_if: request/result bundle between the sequencer and the ALU stage.
//   Request (master -> slave): start, op, operand, cy_in.
//   Result  (slave -> master): acc, mul_hi, busy, done, ce_cy, cy_new, ov_new.
interface alu_acc_if import cpu_pkg::*; #(parameter int W = ACC_W);

  logic         start;
  alu_op_t      op;
  logic [W-1:0] operand;
  logic         cy_in;

  logic [W-1:0] acc;
  logic [W-1:0] mul_hi;
  logic         busy;
  logic         done;
  logic         ce_cy;
  logic         cy_new;
  logic         ov_new;

  modport master (
    output start, op, operand, cy_in,
    input  acc, mul_hi, busy, done, ce_cy, cy_new, ov_new
  );

  modport slave (
    input  start, op, operand, cy_in,
    output acc, mul_hi, busy, done, ce_cy, cy_new, ov_new
  );

endinterface

// File: rtl/alu_acc_mul_seq.sv
// mul_seq: unsigned W x W shift-add multiplier, one iteration per clock.
//   clk, rst  : clock and synchronous active-high reset.
//   start     : load mcand/mplier, clear the partial product, restart the count.
//   mcand     : multiplicand, sampled on start.
//   mplier    : multiplier, sampled on start.
//   last      : high during the final iteration cycle.
//   prod_next : product after the current cycle's iteration; holds the full
//               2W-bit result while last is high.
module mul_seq #(parameter int W = 8) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           last,
  output logic [2*W-1:0] prod_next
);

  localparam int CW = $clog2(W);

  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           active_q, active_d;
  logic [W:0]     step_sum;
  logic [2*W-1:0] prod_step;

  // The multiplier sits in the low half of prod and is consumed LSB first;
  // the upper half accumulates, and the whole register shifts right each step
  // so the carry out of the add lands in the top bit.
  always_comb begin
    step_sum  = {1'b0, prod_q[2*W-1:W]} + ({1'b0, mcand_q} & {(W+1){prod_q[0]}});
    prod_step = {step_sum, prod_q[W-1:1]};

    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    active_d = active_q;

    if (start) begin
      mcand_d  = mcand;
      prod_d   = {{W{1'b0}}, mplier};
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      prod_d = prod_step;
      cnt_d  = cnt_q + CW'(1);
      if (last) begin
        active_d = 1'b0;
      end
    end
  end

  assign last      = active_q && (cnt_q == CW'(W - 1));
  assign prod_next = prod_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_acc.sv
// alu_acc: accumulator-holding ALU stage feeding the flags register block.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : alu_acc_if.slave -- start/op/operand/cy_in in; acc, mul_hi,
//              busy, done, ce_cy, cy_new, ov_new out (all registered).
// Build option ALU_MUL_EN: when defined, OP_MUL runs an 8-iteration sequential
// multiply with busy/done handshake and mul_hi; when undefined OP_MUL is a NOP
// and busy/mul_hi stay 0.
module alu_acc import cpu_pkg::*; #(parameter int W = ACC_W) (
  input logic        clk,
  input logic        rst,
  alu_acc_if.slave   bus
);

  localparam int WE = W + 1;

  alu_state_t   state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic         done_q, done_d;
  logic         ce_cy_q, ce_cy_d;
  logic         cy_q, cy_d;
  logic         ov_q, ov_d;
  logic         add_cin, sub_bin;
  logic [WE-1:0] add_ext, sub_ext;

`ifdef ALU_MUL_EN
  logic [W-1:0]   mul_hi_q, mul_hi_d;
  logic           mul_start;
  logic           mul_last;
  logic [2*W-1:0] mul_prod;

  mul_seq #(.W(W)) u_mul_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .mcand     (acc_q),
    .mplier    (bus.operand),
    .last      (mul_last),
    .prod_next (mul_prod)
  );
`endif

  // Add/subtract at W+1 bits so bit W is the carry (add) or the borrow
  // (subtract wraps negative when the minuend is the smaller value).
  always_comb begin
    add_cin = (bus.op == OP_ADC) && bus.cy_in;
    sub_bin = (bus.op == OP_SBC) && bus.cy_in;
    add_ext = {1'b0, acc_q} + {1'b0, bus.operand} + WE'(add_cin);
    sub_ext = {1'b0, acc_q} - {1'b0, bus.operand} - WE'(sub_bin);
  end

  // Next-state logic. Every accepted non-MUL op completes in the cycle it is
  // sampled, so done can be high while the next start is accepted. Flags
  // hold their last values whenever ce_cy is low.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    ce_cy_d = 1'b0;
    cy_d    = cy_q;
    ov_d    = ov_q;
`ifdef ALU_MUL_EN
    mul_hi_d  = mul_hi_q;
    mul_start = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          done_d = 1'b1;
          case (bus.op)
            OP_LD:  acc_d = bus.operand;
            OP_AND: acc_d = acc_q & bus.operand;
            OP_OR:  acc_d = acc_q | bus.operand;
            OP_XOR: acc_d = acc_q ^ bus.operand;
            OP_ADD, OP_ADC: begin
              acc_d   = add_ext[W-1:0];
              cy_d    = add_ext[W];
              ov_d    = (acc_q[W-1] == bus.operand[W-1]) && (add_ext[W-1] != acc_q[W-1]);
              ce_cy_d = 1'b1;
            end
            OP_SUB, OP_SBC: begin
              acc_d   = sub_ext[W-1:0];
              cy_d    = sub_ext[W];
              ov_d    = (acc_q[W-1] != bus.operand[W-1]) && (sub_ext[W-1] != acc_q[W-1]);
              ce_cy_d = 1'b1;
            end
            OP_SHL: begin
              acc_d   = {acc_q[W-2:0], 1'b0};
              cy_d    = acc_q[W-1];
              ov_d    = acc_q[W-1] ^ acc_q[W-2];
              ce_cy_d = 1'b1;
            end
            OP_SHR: begin
              acc_d   = {1'b0, acc_q[W-1:1]};
              cy_d    = acc_q[0];
              ov_d    = 1'b0;
              ce_cy_d = 1'b1;
            end
            OP_RLC: begin
              acc_d   = {acc_q[W-2:0], bus.cy_in};
              cy_d    = acc_q[W-1];
              ov_d    = 1'b0;
              ce_cy_d = 1'b1;
            end
            OP_RRC: begin
              acc_d   = {bus.cy_in, acc_q[W-1:1]};
              cy_d    = acc_q[0];
              ov_d    = 1'b0;
              ce_cy_d = 1'b1;
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
              done_d    = 1'b0;
              mul_start = 1'b1;
              state_d   = ST_MUL;
            end
`endif
            default: acc_d = acc_q;
          endcase
        end
      end
`ifdef ALU_MUL_EN
      // acc stays put while iterating; new starts are dropped here.
      ST_MUL: begin
        if (mul_last) begin
          acc_d    = mul_prod[W-1:0];
          mul_hi_d = mul_prod[2*W-1:W];
          cy_d     = |mul_prod[2*W-1:W];
          ov_d     = |mul_prod[2*W-1:W];
          ce_cy_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset also aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      done_q  <= 1'b0;
      ce_cy_q <= 1'b0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef ALU_MUL_EN
      mul_hi_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      ce_cy_q <= ce_cy_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
`ifdef ALU_MUL_EN
      mul_hi_q <= mul_hi_d;
`endif
    end
  end

  assign bus.acc    = acc_q;
  assign bus.busy   = (state_q == ST_MUL);
  assign bus.done   = done_q;
  assign bus.ce_cy  = ce_cy_q;
  assign bus.cy_new = cy_q;
  assign bus.ov_new = ov_q;
`ifdef ALU_MUL_EN
  assign bus.mul_hi = mul_hi_q;
`else
  assign bus.mul_hi = '0;
`endif

endmodule
